fw_loader: RTL and testbench

Hardware firmware loader that sits directly upstream of the system memory. It consumes an ASCII hex character stream, one byte per two hex digits with `#` comments to end-of-line. Decoded bytes are written sequentially into memory starting at the instruction base, and the CPU is held in reset until loading completes. It replaces ad-hoc bench-side file parsing with a synthesizable, verifiable path from image to memory.

---
 rtl/fw_loader_pkg.sv | 41 ++++
 rtl/fw_loader_hex.sv | 22 ++
 rtl/fw_loader.sv | 146 ++++++++++++++
 tb/tb_fw_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_loader_pkg.sv
// fw_loader_pkg: loader state encoding, ASCII constants and memory-map defaults.
// The memory-map macros may be supplied by the build; the values below are fallbacks.
`ifndef INSTRUCTION_BASE
`define INSTRUCTION_BASE 48
`endif
`ifndef MEM_DEPTH
`define MEM_DEPTH 64
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

package fw_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_COMMENT,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } fw_ld_state_t;

  localparam logic [7:0] ASCII_HASH  = 8'h23;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_NUL   = 8'h00;

  // Separators tolerated between bytes (never between the two digits of a byte).
  function automatic logic is_blank(input logic [7:0] c);
    return (c == ASCII_SPACE) || (c == ASCII_TAB) || (c == ASCII_CR) ||
           (c == ASCII_LF) || (c == ASCII_NUL);
  endfunction

endpackage

// File: rtl/fw_loader_hex.sv
// hex_char_decode: combinational ASCII hex digit decoder (0-9, A-F, a-f).
module hex_char_decode (
  input  logic [7:0] i_char,
  output logic [3:0] o_nibble,
  output logic       o_is_hex
);

  always_comb begin
    o_nibble = 4'h0;
    o_is_hex = 1'b0;
    if (i_char >= 8'h30 && i_char <= 8'h39) begin
      o_nibble = i_char[3:0];
      o_is_hex = 1'b1;
    end else if ((i_char >= 8'h41 && i_char <= 8'h46) ||
                 (i_char >= 8'h61 && i_char <= 8'h66)) begin
      // Both letter ranges have low nibble 1..6 for A..F.
      o_nibble = i_char[3:0] + 4'd9;
      o_is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/fw_loader.sv
// fw_loader: parses an ASCII hex image into sequential memory writes, holding the CPU in reset.
// Optional build macro FW_LOADER_CHECKSUM_EN enables the 8-bit running checksum of written bytes.
module fw_loader
  import fw_loader_pkg::*;
#(
  parameter int BASE_ADDR = `INSTRUCTION_BASE,
  parameter int DEPTH     = `MEM_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   ch_valid,
  input  logic [7:0]             ch_data,
  output logic                   ch_ready,
  input  logic                   eof,
  output logic                   mem_we,
  output logic [`ADDR_WIDTH-1:0] mem_addr,
  output logic [`REG_WIDTH-1:0]  mem_din,
  output logic [`ADDR_WIDTH-1:0] byte_count,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [7:0]             checksum,
  output logic                   cpu_reset_n
);

  localparam int AW = `ADDR_WIDTH;
  localparam int RW = `REG_WIDTH;
  localparam logic [AW-1:0] BASE  = AW'(BASE_ADDR);
  // ADDR_WIDTH must be wide enough to hold DEPTH itself (one past the last write).
  localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

  fw_ld_state_t  r_state, w_next;
  logic [AW-1:0] r_addr, r_count;
  logic [3:0]    r_high;
  logic [7:0]    r_din;
  logic          r_eof_pend, r_cpu_rst_n;
  logic [3:0]    w_nibble;
  logic          w_is_hex, w_accept, w_start_ok;

  hex_char_decode u_dec (
    .i_char   (ch_data),
    .o_nibble (w_nibble),
    .o_is_hex (w_is_hex)
  );

  assign ch_ready   = (r_state == ST_HIGH) || (r_state == ST_LOW) || (r_state == ST_COMMENT);
  assign w_accept   = ch_valid & ch_ready;
  assign w_start_ok = start & ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) w_next = ST_HIGH;
      ST_HIGH: begin
        if (r_eof_pend)                  w_next = ST_DONE;
        else if (w_accept) begin
          if (w_is_hex)                  w_next = ST_LOW;
          else if (ch_data == ASCII_HASH) w_next = ST_COMMENT;
          else if (!is_blank(ch_data))   w_next = ST_ERROR;
        end else if (eof)                w_next = ST_DONE;
      end
      ST_LOW: begin
        if (w_accept) begin
          if (!w_is_hex || r_addr == LIMIT) w_next = ST_ERROR;
          else                              w_next = ST_WRITE;
        end else if (eof)                   w_next = ST_ERROR;
      end
      ST_COMMENT: begin
        if (r_eof_pend)                     w_next = ST_DONE;
        else if (w_accept) begin
          if (ch_data == ASCII_LF)          w_next = ST_HIGH;
        end else if (eof)                   w_next = ST_DONE;
      end
      ST_WRITE: w_next = ST_HIGH;
      default:  w_next = ST_IDLE;
    endcase
  end

  // An eof that cannot be acted on this cycle is remembered until the next HIGH/COMMENT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_eof_pend <= 1'b0;
    end else if (w_start_ok || w_next == ST_DONE || w_next == ST_ERROR) begin
      r_eof_pend <= 1'b0;
    end else if (eof && (r_state == ST_WRITE || w_accept)) begin
      r_eof_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= BASE;
      r_count <= '0;
      r_high  <= 4'h0;
      r_din   <= 8'h00;
    end else if (w_start_ok) begin
      r_addr  <= BASE;
      r_count <= '0;
    end else begin
      if (r_state == ST_HIGH && w_accept && w_is_hex) r_high <= w_nibble;
      if (r_state == ST_LOW && w_next == ST_WRITE)    r_din  <= {r_high, w_nibble};
      if (r_state == ST_WRITE) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count + 1'b1;
      end
    end
  end

`ifdef FW_LOADER_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_checksum <= 8'h00;
    else if (w_start_ok)         r_checksum <= 8'h00;
    else if (r_state == ST_WRITE) r_checksum <= r_checksum + r_din;
  end

  assign checksum = r_checksum;
`else
  assign checksum = 8'h00;
`endif

  // CPU is released one cycle after DONE and pulled back into reset by a new load or an abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 r_cpu_rst_n <= 1'b0;
    else if (w_start_ok)          r_cpu_rst_n <= 1'b0;
    else if (r_state == ST_DONE)  r_cpu_rst_n <= 1'b1;
    else if (r_state == ST_ERROR) r_cpu_rst_n <= 1'b0;
  end

  assign mem_we      = (r_state == ST_WRITE);
  assign mem_addr    = r_addr;
  assign mem_din     = RW'(r_din);
  assign byte_count  = r_count;
  assign busy        = ch_ready || (r_state == ST_WRITE);
  assign done        = (r_state == ST_DONE);
  assign err         = (r_state == ST_ERROR);
  assign cpu_reset_n = r_cpu_rst_n;

endmodule

// File: tb/tb_fw_loader.sv
// tb_fw_loader: randomized image loads checked by a write scoreboard and an image-parsing model.
`ifndef INSTRUCTION_BASE
`define INSTRUCTION_BASE 48
`endif
`ifndef MEM_DEPTH
`define MEM_DEPTH 64
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module tb_fw_loader;

  localparam int BASE  = `INSTRUCTION_BASE;
  localparam int DEPTH = `MEM_DEPTH;
  localparam int CAP   = DEPTH - BASE;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   start = 1'b0;
  logic                   ch_valid = 1'b0;
  logic [7:0]             ch_data = 8'h00;
  logic                   eof = 1'b0;
  logic                   ch_ready, mem_we, busy, done, err, cpu_reset_n;
  logic [`ADDR_WIDTH-1:0] mem_addr, byte_count;
  logic [`REG_WIDTH-1:0]  mem_din;
  logic [7:0]             checksum;

  fw_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .ch_valid    (ch_valid),
    .ch_data     (ch_data),
    .ch_ready    (ch_ready),
    .eof         (eof),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .byte_count  (byte_count),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .checksum    (checksum),
    .cpu_reset_n (cpu_reset_n)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int expAddr[$];
  int expData[$];
  byte unsigned img[$];
  int modelBytes[$];
  int modelSend;
  bit modelErr;
  bit modelEofErr;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next expected (address, byte).
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      checkOutput("ch_ready during write", 32'(ch_ready), 0);
      if (expAddr.size() == 0) begin
        checkOutput("spurious write", 32'(mem_we), 0);
      end else begin
        checkOutput("write addr", 32'(mem_addr), expAddr.pop_front());
        checkOutput("write data", 32'(mem_din), expData.pop_front());
      end
    end
  end

  function automatic bit isHexC(input int c);
    return (c >= 48 && c <= 57) || (c >= 65 && c <= 70) || (c >= 97 && c <= 102);
  endfunction

  function automatic int hexVal(input int c);
    if (c <= 57) return c - 48;
    if (c >= 97) return c - 87;
    return c - 55;
  endfunction

  // Reference parse of the whole image: byte list, outcome, and how many characters get consumed.
  task automatic runModel();
    bit inComment = 0;
    bit haveHigh = 0;
    int hi = 0;
    int c;
    modelBytes.delete();
    modelErr = 0;
    modelEofErr = 0;
    modelSend = img.size();
    for (int i = 0; i < img.size(); i++) begin
      c = int'(img[i]);
      if (inComment) begin
        if (c == 10) inComment = 0;
      end else if (isHexC(c)) begin
        if (!haveHigh) begin
          haveHigh = 1;
          hi = hexVal(c);
        end else begin
          haveHigh = 0;
          if (modelBytes.size() >= CAP) begin
            modelErr = 1;
            modelSend = i + 1;
            return;
          end
          modelBytes.push_back(hi * 16 + hexVal(c));
        end
      end else if (haveHigh || !(c == 32 || c == 9 || c == 13 || c == 10 || c == 0 || c == 35)) begin
        modelErr = 1;
        modelSend = i + 1;
        return;
      end else if (c == 35) begin
        inComment = 1;
      end
    end
    if (haveHigh) begin
      modelErr = 1;
      modelEofErr = 1;
    end
  endtask

  task automatic loadString(input string s);
    img.delete();
    for (int i = 0; i < s.len(); i++) img.push_back(s[i]);
  endtask

  task automatic pushHexDigit(input int v);
    if (v < 10) img.push_back(byte'(48 + v));
    else if ($urandom_range(0, 1) == 1) img.push_back(byte'(55 + v));
    else img.push_back(byte'(87 + v));
  endtask

  task automatic buildRandomImage(input int nBytes, input int errKind);
    int sep;
    img.delete();
    for (int k = 0; k < nBytes; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        img.push_back(8'h23);
        repeat ($urandom_range(0, 5)) img.push_back(byte'($urandom_range(32, 126)));
        img.push_back(8'h0A);
      end
      pushHexDigit($urandom_range(0, 15));
      pushHexDigit($urandom_range(0, 15));
      sep = $urandom_range(0, 6);
      case (sep)
        0: img.push_back(8'h20);
        1: img.push_back(8'h09);
        2: img.push_back(8'h0D);
        3: img.push_back(8'h0A);
        4: img.push_back(8'h00);
        default: ;
      endcase
    end
    if (errKind == 1) img.push_back(8'h78);
    if (errKind == 2) pushHexDigit($urandom_range(0, 15));
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic sendChar(input byte unsigned c, input bit withEof);
    int budget = 0;
    ch_valid = 1'b1;
    ch_data = c;
    @(negedge clk);
    while (!ch_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!ch_ready) begin
      checkOutput("ch_ready timeout", 32'(ch_ready), 1);
      ch_valid = 1'b0;
      return;
    end
    if (withEof) eof = 1'b1;
    @(posedge clk); #1;
    ch_valid = 1'b0;
    eof = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " ch_ready"}, 32'(ch_ready), 0);
    checkOutput({tag, " mem_we"}, 32'(mem_we), 0);
    checkOutput({tag, " mem_addr"}, 32'(mem_addr), BASE);
    checkOutput({tag, " mem_din"}, 32'(mem_din), 0);
    checkOutput({tag, " byte_count"}, 32'(byte_count), 0);
    checkOutput({tag, " checksum"}, 32'(checksum), 0);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " done"}, 32'(done), 0);
    checkOutput({tag, " err"}, 32'(err), 0);
    checkOutput({tag, " cpu_reset_n"}, 32'(cpu_reset_n), 0);
  endtask

  // Streams img through the loader, with expected writes queued before the first character.
  task automatic applyStimulus(input bit eofWithLast);
    int expSum = 0;
    int cyc = 0;
    runModel();
    foreach (modelBytes[k]) begin
      expAddr.push_back(BASE + k);
      expData.push_back(modelBytes[k]);
      expSum += modelBytes[k];
    end
`ifndef FW_LOADER_CHECKSUM_EN
    expSum = 0;
`endif
    pulseStart();
    for (int i = 0; i < modelSend; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      sendChar(img[i], eofWithLast && (i == modelSend - 1));
    end
    if ((!modelErr || modelEofErr) && !eofWithLast) begin
      eof = 1'b1;
      @(posedge clk); #1;
      eof = 1'b0;
    end
    @(negedge clk);
    while (!(done || err) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("done", 32'(done), 32'(!modelErr));
    checkOutput("err", 32'(err), 32'(modelErr));
    checkOutput("byte_count", 32'(byte_count), modelBytes.size());
    checkOutput("checksum", 32'(checksum), expSum & 255);
    checkOutput("busy at end", 32'(busy), 0);
    checkOutput("cpu_reset_n on entry", 32'(cpu_reset_n), 0);
    @(negedge clk);
    checkOutput("cpu_reset_n next cycle", 32'(cpu_reset_n), 32'(!modelErr));
    checkOutput("scoreboard drained", expAddr.size(), 0);
    expAddr.delete();
    expData.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    checkResetValues("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    loadString("A9 01 8d");
    applyStimulus(1'b0);
    loadString("# load\nff");
    applyStimulus(1'b0);
    loadString("F ");
    applyStimulus(1'b0);

    buildRandomImage(CAP + 1, 0);
    applyStimulus(1'b0);

    loadString("12");
    applyStimulus(1'b1);

    pulseStart();
    sendChar(8'h35, 1'b0);
    sendChar(8'h36, 1'b0);
    checkOutput("mem_we before reset", 32'(mem_we), 1);
    reset_n = 1'b0;
    #1;
    checkResetValues("mid-write reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    loadString("ab");
    applyStimulus(1'b0);

    for (int t = 0; t < 25; t++) begin
      int kind = $urandom_range(0, 9);
      int n = (kind == 3) ? CAP + $urandom_range(1, 2) : $urandom_range(1, CAP);
      buildRandomImage(n, (kind < 3) ? kind : 0);
      applyStimulus(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
